bcd_seg_scan: RTL
=================

# bcd_seg_scan

Time-multiplexed seven-segment display driver for a multi-digit BCD counter. It sits directly downstream of the BCD counter stage and consumes its packed 4-bit digits. It latches a display value, scans one digit at a time with a programmable dwell, decodes BCD to segments, and optionally blanks leading zeros. It also emits a frame pulse once per full scan.

## Interface
- NUM_DIGITS, 4: number of BCD digits scanned (≥1)
- SCAN_DIV, 4: clock cycles each digit stays active (≥1)
- clk  input  1  system clock, all state on rising edge
- rst_asyn  input  1  reset, synchronous, active-low
- digits_i  input  4*NUM_DIGITS  packed BCD; digit k = digits_i[4k+3:4k], k=0 least significant
- load_i  input  1  latch digits_i into display register this edge
- blank_lz_i  input  1  enable leading-zero blanking
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-high, registered
- an_o  output  NUM_DIGITS  one-hot digit enable, active-high, registered
- frame_o  output  1  one-cycle pulse on last active cycle of digit NUM_DIGITS-1

## Operation
- State: disp (4*NUM_DIGITS), presc (0..SCAN_DIV-1), idx (0..NUM_DIGITS-1).
- Reset (rst_asyn=0 at edge): disp=0, presc=0, idx=0, seg_o=0, an_o=0, frame_o=0. Reset overrides load_i.
- Load: load_i=1 → disp<=digits_i. No handshake; the value is held until the next load.
- Prescaler: presc increments each cycle. At SCAN_DIV-1 it wraps to 0 and idx advances mod NUM_DIGITS (NUM_DIGITS-1 → 0).
- Output registers, updated every non-reset edge from the pre-edge state:
  - an_o<=1<<idx
  - seg_o<=decode(disp[idx]), or 0 if blanked
  - frame_o<=(presc==SCAN_DIV-1 && idx==NUM_DIGITS-1)
- Decode: 0→0111111, 1→0000110, 2→1011011, 3→1001111, 4→1100110, 5→1101101, 6→1111101, 7→0000111, 8→1111111, 9→1101111, 10–15 (invalid)→1000000 (dash).
- Blanking: with blank_lz_i=1, digit k>0 is blanked iff digits k..NUM_DIGITS-1 are all 0x0. Digit 0 is never blanked. Invalid codes count as nonzero. A blanked digit keeps its an_o bit high and drives seg_o=0.

## Timing
- One-cycle latency: state at edge n appears on outputs after edge n+1.
- First edge after reset release: an_o=0001, seg_o=0111111 (disp=0).
- Each digit is active SCAN_DIV consecutive cycles; a full frame takes NUM_DIGITS*SCAN_DIV cycles. frame_o is high exactly once per frame.
- load_i at edge n: disp changes at edge n. Outputs after edge n+1 use the new value for the currently indexed digit; a mid-slot change shows immediately. Load does not affect presc or idx.
- Load coincident with a slot boundary: the new digit is decoded with the new value, with no stale cycle.
- SCAN_DIV=1: presc is constant 0 and idx advances every cycle.
- blank_lz_i change: takes effect on the next output update.

## Structure
- Package bcd_seg_pkg holds:
  - the 7-bit segment constants for 0–9
  - SEG_DASH=7'b1000000
  - SEG_OFF=7'b0000000
  - the digit width constant BCD_W=4
- Sub-module bcd_seg_decode: combinational 4-bit→7-bit decoder using the package constants.
- Leading-zero mask (NUM_DIGITS bits), prescaler, index counter and output registers live in bcd_seg_scan.

## Test plan
(NUM_DIGITS=4, SCAN_DIV=4 unless noted)
- Reset: rst_asyn=0 for 3 cycles → an_o=0000, seg_o=0000000, frame_o=0. After release, first edge gives an_o=0001, seg_o=0111111.
- Scan: load 16'h1234, blank off → an_o 0001/0010/0100/1000 for 4 cycles each, with seg_o 1100110/1001111/1011011/0000110. frame_o pulses every 16 cycles, during the last 1000 cycle.
- Blanking: load 16'h0070, blank_lz_i=1 → digits 3 and 2 give seg_o=0000000 with an_o still stepping; digit 1 gives 0000111; digit 0 gives 0111111. With blank_lz_i=0, digit 3 gives 0111111.
- Invalid code: load 16'h00A0, blank on → digit 1 gives 1000000; digits 3 and 2 blank; digit 0 gives 0111111.
- Reset mid-scan: assert at idx=2, presc=1 → next edge all outputs 0 and disp=0. After release, scan restarts at an_o=0001 showing 0111111.
- Load at boundary: load 16'h9999 on the edge where presc wraps from 3 → the first cycle of the next digit shows seg_o=1101111, with no stale value.

Source files
------------

// File: rtl/bcd_seg_pkg.sv
// Shared constants for the BCD seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package bcd_seg_pkg;

   localparam int BCD_W = 4;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0    = 7'b0111111;
   localparam seg_t SEG_1    = 7'b0000110;
   localparam seg_t SEG_2    = 7'b1011011;
   localparam seg_t SEG_3    = 7'b1001111;
   localparam seg_t SEG_4    = 7'b1100110;
   localparam seg_t SEG_5    = 7'b1101101;
   localparam seg_t SEG_6    = 7'b1111101;
   localparam seg_t SEG_7    = 7'b0000111;
   localparam seg_t SEG_8    = 7'b1111111;
   localparam seg_t SEG_9    = 7'b1101111;
   localparam seg_t SEG_DASH = 7'b1000000;
   localparam seg_t SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD to seven-segment decoder; codes 10-15 show a dash.
module bcd_seg_decode
   import bcd_seg_pkg::*;
(
   input  logic [BCD_W-1:0] bcd_i,
   output seg_t             seg_o
);

   // NOTE: the default arm covers every code not listed, so seg_o is
   // assigned on all paths and no latch is inferred.
   always_comb begin
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed seven-segment driver: latches packed BCD digits, scans
// them with a programmable dwell, blanks leading zeros, pulses once per frame.
module bcd_seg_scan
   import bcd_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 4
) (
   input  logic                        clk,
   input  logic                        rst_asyn,
   input  logic [BCD_W*NUM_DIGITS-1:0] digits_i,
   input  logic                        load_i,
   input  logic                        blank_lz_i,
   output logic [6:0]                  seg_o,
   output logic [NUM_DIGITS-1:0]       an_o,
   output logic                        frame_o
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   logic [BCD_W*NUM_DIGITS-1:0] disp_q, disp_d;
   logic [PW-1:0]               presc_q, presc_d;
   logic [IW-1:0]               idx_q, idx_d;
   logic [NUM_DIGITS-1:0]       blank_mask, an_d;
   logic [BCD_W-1:0]            cur_digit;
   seg_t                        dec_seg, seg_d;
   logic                        slot_end, frame_d, upper_zero;

   always_comb begin
      disp_d   = load_i ? digits_i : disp_q;
      slot_end = (presc_q == PRESC_LAST);
      presc_d  = slot_end ? '0 : presc_q + 1'b1;
      idx_d    = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // Walk from the most significant digit down; a digit blanks while every
   // digit above it (and itself) is zero. Digit 0 is never in the mask.
   always_comb begin
      upper_zero = 1'b1;
      blank_mask = '0;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         upper_zero    = upper_zero && (disp_q[k*BCD_W +: BCD_W] == '0);
         blank_mask[k] = blank_lz_i && upper_zero;
      end
   end

   assign cur_digit = disp_q[int'(idx_q)*BCD_W +: BCD_W];

   bcd_seg_decode u_decode (
      .bcd_i (cur_digit),
      .seg_o (dec_seg)
   );

   always_comb begin
      an_d        = '0;
      an_d[idx_q] = 1'b1;
      seg_d       = blank_mask[idx_q] ? SEG_OFF : dec_seg;
      frame_d     = slot_end && (idx_q == IDX_LAST);
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values; the display register is reset along with the rest
   // because the first post-reset frame must show zeros.
   always_ff @(posedge clk) begin
      if (!rst_asyn) begin
         disp_q  <= '0;
         presc_q <= '0;
         idx_q   <= '0;
         seg_o   <= SEG_OFF;
         an_o    <= '0;
         frame_o <= 1'b0;
      end else begin
         disp_q  <= disp_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         seg_o   <= seg_d;
         an_o    <= an_d;
         frame_o <= frame_d;
      end
   end

endmodule
